// File: rtl/verinject_pkg.sv
// ---------------------------------------------------------------------------
// verinject_pkg
//
// Shared definitions for the fault-injection campaign controller:
//   IDLE_STATE      value of the injector-state bus when nothing is injected
//   LFSR_POLY       Galois feedback mask for taps 32,22,2,1
//   IDX_W / CNT_W   widths of bit indices and of the cycle/injection counters
//   sched_state_e   scheduler FSM states
//   lfsr_step()     one Galois LFSR advance
//   range_mask()    all-ones mask covering an index space of 2^aw entries
// ---------------------------------------------------------------------------
package verinject_pkg;

    localparam int IDX_W = 32;
    localparam int CNT_W = 16;

    localparam logic [IDX_W-1:0] IDLE_STATE = 32'hFFFF_FFFF;
    localparam logic [31:0]      LFSR_POLY  = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PICK,
        ST_INJECT,
        ST_GAP
    } sched_state_e;

    // Right-shifting Galois form: the bit shifted out selects whether the
    // polynomial is folded back in. A nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_POLY) : shifted;
    endfunction

    function automatic logic [31:0] range_mask(input int unsigned aw);
        logic [31:0] m;
        if (aw >= 32) begin
            m = 32'hFFFF_FFFF;
        end else begin
            m = (32'd1 << aw) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/verinject_lfsr32.sv
// ---------------------------------------------------------------------------
// verinject_lfsr32
//
// 32-bit Galois LFSR used to draw random injection targets.
//   clock   in   single clock
//   enable  in   advance the sequence by one step
//   load    in   load seed (takes priority over enable); the owner drives
//               this from its reset so the sequence restarts on reset
//   seed    in   32-bit load value; zero is replaced by 1
//   state   out  current 32-bit state, never zero
// ---------------------------------------------------------------------------
module verinject_lfsr32
    import verinject_pkg::*;
(
    input  logic        clock,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    // The all-zero state is the one fixed point of the register, so a zero
    // seed is swapped for 1 to keep the sequence alive.
    always_ff @(posedge clock) begin
        if (load) begin
            state <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/verinject_injection_scheduler.sv
// ---------------------------------------------------------------------------
// verinject_injection_scheduler
//
// Campaign controller driving the shared verinject__injector_state bus seen
// by every injector. Steps through flattened fault-bit indices, holding each
// for a programmable number of cycles with idle gaps in between. Targets are
// swept deterministically (first, first+stride, ... mod TOTAL_BITS) or drawn
// from an LFSR and filtered to the legal range.
//
// Parameters
//   TOTAL_BITS   size of the flattened injectable bit space (<= 32'hFFFF_FFFE)
//   LFSR_SEED    nonzero seed loaded into the LFSR on reset
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   cfg_valid / cfg_ready        config handshake; ready only in IDLE
//   cfg_mode                     0 = sweep, 1 = random
//   cfg_first, cfg_stride        sweep start index and increment
//   cfg_count                    injections per campaign
//   cfg_delay                    cycles from start to the first PICK
//   cfg_hold                     cycles per target (0 behaves as 1)
//   cfg_gap                      idle cycles between injections
//   cfg_error                    sticky; set by a rejected config
//   start, abort                 campaign control; abort wins over all else
//   verinject__injector_state    registered target or IDLE_STATE
//   inject_active, busy          status
//   done, aborted                one-cycle completion / abort pulses
//   injections_done              completed injections this campaign
// ---------------------------------------------------------------------------
module verinject_injection_scheduler
    import verinject_pkg::*;
#(
    parameter logic [31:0] TOTAL_BITS = 32'd1024,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_mode,
    input  logic [IDX_W-1:0] cfg_first,
    input  logic [IDX_W-1:0] cfg_stride,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_hold,
    input  logic [CNT_W-1:0] cfg_gap,
    output logic             cfg_error,

    input  logic             start,
    input  logic             abort,

    output logic [IDX_W-1:0] verinject__injector_state,
    output logic             inject_active,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] injections_done
);

    // Random draws are masked to the smallest power-of-two range that covers
    // TOTAL_BITS, then out-of-range values are rejected.
    localparam logic [31:0] RAND_MASK = range_mask($clog2(TOTAL_BITS));

    sched_state_e     state;

    // Loaded configuration
    logic             mode_q;
    logic [IDX_W-1:0] first_q;
    logic [IDX_W-1:0] stride_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] gap_q;
    logic             cfg_loaded;

    // Shared down-counter for DELAY, INJECT and GAP; the state says which.
    logic [CNT_W-1:0] cnt;
    // Sweep target to be presented at the next PICK.
    logic [IDX_W-1:0] next_target;

    logic [31:0]      lfsr_state;
    logic             lfsr_en;

    logic             cfg_accept;
    logic             cfg_bad;
    logic             start_ok;
    logic [IDX_W:0]   sweep_sum;
    logic [IDX_W-1:0] sweep_next;
    logic [31:0]      rand_value;
    logic             rand_ok;
    logic [CNT_W-1:0] hold_m1;
    logic [CNT_W-1:0] inj_next;
    logic             last_inj;

    assign cfg_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign inject_active = (state == ST_INJECT);

    assign cfg_accept = cfg_valid && (state == ST_IDLE);
    // Stride only matters for sweeping, so random mode does not check it.
    assign cfg_bad    = (cfg_first >= TOTAL_BITS) ||
                        (!cfg_mode && (cfg_stride >= TOTAL_BITS));
    // A start arriving together with a new config is dropped: the campaign
    // always runs against a config that was already checked and loaded.
    assign start_ok   = start && (state == ST_IDLE) && cfg_loaded && !cfg_accept;

    // Both operands are below TOTAL_BITS, so one conditional subtraction
    // brings the 33-bit sum back into range. The low 32 bits of the
    // difference are exact because the true result fits in 32 bits.
    assign sweep_sum  = {1'b0, next_target} + {1'b0, stride_q};
    assign sweep_next = (sweep_sum >= {1'b0, TOTAL_BITS})
                        ? (sweep_sum[IDX_W-1:0] - TOTAL_BITS)
                        : sweep_sum[IDX_W-1:0];

    assign rand_value = lfsr_state & RAND_MASK;
    assign rand_ok    = (rand_value < TOTAL_BITS);
    assign lfsr_en    = (state == ST_PICK) && mode_q;

    assign hold_m1  = (hold_q == '0) ? '0 : (hold_q - 16'd1);
    assign inj_next = injections_done + 16'd1;
    assign last_inj = (inj_next == count_q);

    verinject_lfsr32 u_lfsr (
        .clock  (clock),
        .enable (lfsr_en),
        .load   (reset),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    // NOTE: every register below is assigned with <= so all of them sample
    // the pre-edge values; blocking assignments here would let later
    // statements see half-updated state and break the cycle timing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                     <= ST_IDLE;
            mode_q                    <= 1'b0;
            first_q                   <= '0;
            stride_q                  <= '0;
            count_q                   <= '0;
            delay_q                   <= '0;
            hold_q                    <= '0;
            gap_q                     <= '0;
            cfg_loaded                <= 1'b0;
            cfg_error                 <= 1'b0;
            cnt                       <= '0;
            next_target               <= '0;
            verinject__injector_state <= IDLE_STATE;
            done                      <= 1'b0;
            aborted                   <= 1'b0;
            injections_done           <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if (cfg_accept) begin
                mode_q     <= cfg_mode;
                first_q    <= cfg_first;
                stride_q   <= cfg_stride;
                count_q    <= cfg_count;
                delay_q    <= cfg_delay;
                hold_q     <= cfg_hold;
                gap_q      <= cfg_gap;
                cfg_error  <= cfg_bad;
                cfg_loaded <= !cfg_bad;
            end

            if (abort) begin
                state                     <= ST_IDLE;
                verinject__injector_state <= IDLE_STATE;
                aborted                   <= (state != ST_IDLE);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            injections_done <= '0;
                            next_target     <= first_q;
                            if (count_q == '0) begin
                                done <= 1'b1;
                            end else if (delay_q == '0) begin
                                // Zero delay skips DELAY so the first
                                // target still lands two cycles after start.
                                state <= ST_PICK;
                            end else begin
                                state <= ST_DELAY;
                                cnt   <= delay_q - 16'd1;
                            end
                        end
                    end

                    ST_DELAY: begin
                        if (cnt == '0) begin
                            state <= ST_PICK;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end

                    ST_PICK: begin
                        if (!mode_q) begin
                            verinject__injector_state <= next_target;
                            next_target               <= sweep_next;
                            cnt                       <= hold_m1;
                            state                     <= ST_INJECT;
                        end else if (rand_ok) begin
                            verinject__injector_state <= rand_value;
                            cnt                       <= hold_m1;
                            state                     <= ST_INJECT;
                        end
                    end

                    ST_INJECT: begin
                        if (cnt == '0) begin
                            verinject__injector_state <= IDLE_STATE;
                            injections_done           <= inj_next;
                            if (last_inj) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else if (gap_q == '0) begin
                                state <= ST_PICK;
                            end else begin
                                state <= ST_GAP;
                                cnt   <= gap_q - 16'd1;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end

                    ST_GAP: begin
                        if (cnt == '0) begin
                            state <= ST_PICK;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// ---------------------------------------------------------------------------
// tb_verinject_injection_scheduler
//
// Scoreboard bench. Directed campaigns push the injections they should
// produce (target, first cycle, length) and the cycles of done/aborted
// pulses into queues; monitors sampling on the falling edge pop and compare
// whenever the DUT presents an injection or a pulse. A second instance with
// TOTAL_BITS = 40 runs a random campaign that is checked for range, hold
// length, count and spread of targets.
// ---------------------------------------------------------------------------
module tb_verinject_injection_scheduler;

    localparam logic [31:0] EXP_IDLE = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] tgt;
        int          start;
        int          len;
    } inj_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        cfg_valid  = 1'b0;
    logic        cfg_mode   = 1'b0;
    logic [31:0] cfg_first  = '0;
    logic [31:0] cfg_stride = '0;
    logic [15:0] cfg_count  = '0;
    logic [15:0] cfg_delay  = '0;
    logic [15:0] cfg_hold   = '0;
    logic [15:0] cfg_gap    = '0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;

    logic        cfg_ready, cfg_error, inject_active, busy, done, aborted;
    logic [31:0] inj_state;
    logic [15:0] injections_done;

    logic        r_cfg_valid = 1'b0;
    logic        r_start     = 1'b0;
    logic        r_abort     = 1'b0;
    logic        r_cfg_ready, r_cfg_error, r_inject_active, r_busy, r_done, r_aborted;
    logic [31:0] r_inj_state;
    logic [15:0] r_injections_done;

    verinject_injection_scheduler #(.TOTAL_BITS(32'd64)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .cfg_valid                 (cfg_valid),
        .cfg_ready                 (cfg_ready),
        .cfg_mode                  (cfg_mode),
        .cfg_first                 (cfg_first),
        .cfg_stride                (cfg_stride),
        .cfg_count                 (cfg_count),
        .cfg_delay                 (cfg_delay),
        .cfg_hold                  (cfg_hold),
        .cfg_gap                   (cfg_gap),
        .cfg_error                 (cfg_error),
        .start                     (start),
        .abort                     (abort),
        .verinject__injector_state (inj_state),
        .inject_active             (inject_active),
        .busy                      (busy),
        .done                      (done),
        .aborted                   (aborted),
        .injections_done           (injections_done)
    );

    verinject_injection_scheduler #(.TOTAL_BITS(32'd40)) dut_r (
        .clock                     (clock),
        .reset                     (reset),
        .cfg_valid                 (r_cfg_valid),
        .cfg_ready                 (r_cfg_ready),
        .cfg_mode                  (cfg_mode),
        .cfg_first                 (cfg_first),
        .cfg_stride                (cfg_stride),
        .cfg_count                 (cfg_count),
        .cfg_delay                 (cfg_delay),
        .cfg_hold                  (cfg_hold),
        .cfg_gap                   (cfg_gap),
        .cfg_error                 (r_cfg_error),
        .start                     (r_start),
        .abort                     (r_abort),
        .verinject__injector_state (r_inj_state),
        .inject_active             (r_inject_active),
        .busy                      (r_busy),
        .done                      (r_done),
        .aborted                   (r_aborted),
        .injections_done           (r_injections_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    inj_t        inj_q[$];
    int          done_q[$];
    int          abort_q[$];
    logic [31:0] plan[$];

    // Model copy of the loaded timing config for the main instance.
    logic [15:0] m_delay, m_hold, m_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail_event(input string name, input int at);
        checks++;
        failures++;
        $display("FAIL %s: event seen at cycle %0d, none expected", name, at);
    endtask

    // ---------------- monitor: main instance ----------------
    bit          in_run = 1'b0;
    logic [31:0] run_tgt;
    int          run_start, run_len;

    task automatic close_run();
        inj_t e;
        check("inject_active_low_after_run", inject_active, 1'b0);
        if (inj_q.size() == 0) begin
            fail_event("unexpected_injection", run_start);
        end else begin
            e = inj_q.pop_front();
            check("inj_target", run_tgt, e.tgt);
            check("inj_start_cycle", run_start, e.start);
            check("inj_length", run_len, e.len);
        end
    endtask

    always @(negedge clock) begin : mon_main
        int w;
        if (reset) begin
            in_run = 1'b0;
        end else begin
            if (inj_state != EXP_IDLE) begin
                if (in_run && inj_state == run_tgt) begin
                    run_len++;
                end else begin
                    if (in_run) close_run();
                    in_run    = 1'b1;
                    run_tgt   = inj_state;
                    run_start = cyc;
                    run_len   = 1;
                    check("inject_active_high", inject_active, 1'b1);
                end
            end else if (in_run) begin
                close_run();
                in_run = 1'b0;
            end
            if (done) begin
                if (done_q.size() == 0) fail_event("unexpected_done", cyc);
                else begin
                    w = done_q.pop_front();
                    check("done_cycle", cyc, w);
                end
            end
            if (aborted) begin
                if (abort_q.size() == 0) fail_event("unexpected_aborted", cyc);
                else begin
                    w = abort_q.pop_front();
                    check("aborted_cycle", cyc, w);
                end
            end
        end
    end

    // ---------------- monitor: random instance ----------------
    bit          r_in_run = 1'b0;
    logic [31:0] r_tgt;
    int          r_len;
    int          r_runs = 0;
    int          r_done_seen = 0;
    bit          seen[64];

    task automatic close_r_run();
        r_runs++;
        check("rand_target_in_range", r_tgt < 32'd40, 1'b1);
        check("rand_hold_length", r_len, 1);
        if (r_tgt < 32'd40) seen[r_tgt[5:0]] = 1'b1;
    endtask

    always @(negedge clock) begin : mon_rand
        if (reset) begin
            r_in_run = 1'b0;
        end else begin
            if (r_inj_state != EXP_IDLE) begin
                if (r_in_run && r_inj_state == r_tgt) begin
                    r_len++;
                end else begin
                    if (r_in_run) close_r_run();
                    r_in_run = 1'b1;
                    r_tgt    = r_inj_state;
                    r_len    = 1;
                end
            end else if (r_in_run) begin
                close_r_run();
                r_in_run = 1'b0;
            end
            if (r_done) r_done_seen++;
            if (r_aborted) fail_event("rand_unexpected_aborted", cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_cfg(input logic mode, input logic [31:0] first, input logic [31:0] stride,
                            input logic [15:0] count, input logic [15:0] delay,
                            input logic [15:0] hold, input logic [15:0] gap,
                            input logic exp_err, input bit to_r);
        @(negedge clock);
        check("cfg_ready", to_r ? r_cfg_ready : cfg_ready, 1'b1);
        cfg_mode   = mode;
        cfg_first  = first;
        cfg_stride = stride;
        cfg_count  = count;
        cfg_delay  = delay;
        cfg_hold   = hold;
        cfg_gap    = gap;
        if (to_r) r_cfg_valid = 1'b1;
        else      cfg_valid   = 1'b1;
        if (!to_r) begin
            m_delay = delay;
            m_hold  = hold;
            m_gap   = gap;
        end
        @(negedge clock);
        cfg_valid   = 1'b0;
        r_cfg_valid = 1'b0;
        check("cfg_error", to_r ? r_cfg_error : cfg_error, exp_err);
    endtask

    // Pushes the expected injections for 'plan' and then pulses start.
    // abort_len > 0: only the first injection is expected, cut to that
    // many cycles, followed by an aborted pulse.
    task automatic launch(input int abort_len, input bit exp_busy, input bit exp_done);
        int   s, st, h, last_end;
        inj_t e;
        @(negedge clock);
        s        = cyc;
        h        = (m_hold == 16'd0) ? 1 : int'(m_hold);
        st       = s + 2 + int'(m_delay);
        last_end = s + 1;
        for (int i = 0; i < plan.size(); i++) begin
            if (abort_len == 0 || i == 0) begin
                e.tgt   = plan[i];
                e.start = st;
                e.len   = (abort_len > 0) ? abort_len : h;
                inj_q.push_back(e);
                if (abort_len > 0) abort_q.push_back(st + abort_len);
                last_end = st + h;
                st       = st + h + int'(m_gap) + 1;
            end
        end
        if (exp_done) done_q.push_back(last_end);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, exp_busy);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clock);
            if (!busy && inj_q.size() == 0 && done_q.size() == 0 && abort_q.size() == 0) ok = 1'b1;
        end
        if (!ok) fail_event({"timeout_", name}, cyc);
    endtask

    task automatic wait_inject_active(input logic level);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (inject_active == level) ok = 1'b1;
        end
        if (!ok) fail_event("timeout_inject_active", cyc);
    endtask

    task automatic check_reset_values();
        check("rst_state", inj_state, EXP_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_inject_active", inject_active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_injections_done", injections_done, 16'd0);
        check("rst_cfg_error", cfg_error, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_r_state", r_inj_state, EXP_IDLE);
        check("rst_r_busy", r_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int distinct;
        int guard;

        // Reset
        repeat (3) @(negedge clock);
        check_reset_values();
        reset = 1'b0;

        // Sweep TOTAL_BITS=64, first=5, stride=20, count=4, hold=2, gap=1
        load_cfg(1'b0, 32'd5, 32'd20, 16'd4, 16'd0, 16'd2, 16'd1, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd5); plan.push_back(32'd25); plan.push_back(32'd45); plan.push_back(32'd1);
        launch(0, 1'b1, 1'b1);
        // A second start mid-campaign must be ignored and must not clear
        // the completed-injection count (first injection ended already).
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart_ignored_inj_done", injections_done, 16'd1);
        wait_idle("sweep_basic");
        check("sweep_basic_inj_done", injections_done, 16'd4);
        check("sweep_basic_idle_state", inj_state, EXP_IDLE);

        // Wrap-around (63+63 -> 62), hold=0 acting as 1, delay=3, gap=0
        load_cfg(1'b0, 32'd63, 32'd63, 16'd3, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd63); plan.push_back(32'd62); plan.push_back(32'd61);
        launch(0, 1'b1, 1'b1);
        wait_idle("sweep_wrap");
        check("sweep_wrap_inj_done", injections_done, 16'd3);

        // Stride 0 repeats the same target
        load_cfg(1'b0, 32'd17, 32'd0, 16'd3, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd17); plan.push_back(32'd17); plan.push_back(32'd17);
        launch(0, 1'b1, 1'b1);
        wait_idle("sweep_stride0");

        // count=0: done on the next cycle, nothing injected
        load_cfg(1'b0, 32'd5, 32'd20, 16'd0, 16'd0, 16'd2, 16'd1, 1'b0, 1'b0);
        plan.delete();
        launch(0, 1'b0, 1'b1);
        check("count0_state", inj_state, EXP_IDLE);
        wait_idle("count0");
        check("count0_inj_done", injections_done, 16'd0);

        // first out of range: error, config unloaded, start ignored
        load_cfg(1'b0, 32'd64, 32'd1, 16'd4, 16'd0, 16'd1, 16'd0, 1'b1, 1'b0);
        plan.delete();
        launch(0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("err_busy_stays_low", busy, 1'b0);
        check("err_sticky", cfg_error, 1'b1);
        // stride out of range in sweep mode
        load_cfg(1'b0, 32'd0, 32'd64, 16'd2, 16'd0, 16'd1, 16'd0, 1'b1, 1'b0);

        // Abort on second INJECT cycle of hold=5; a valid config clears error
        load_cfg(1'b0, 32'd10, 32'd1, 16'd2, 16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd10); plan.push_back(32'd11);
        launch(2, 1'b1, 1'b0);
        wait_inject_active(1'b1);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_state", inj_state, EXP_IDLE);
        check("abort_pulse", aborted, 1'b1);
        check("abort_no_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        wait_idle("abort");
        // abort while idle gives no pulse (monitor flags any)
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (2) @(negedge clock);
        // Config is still loaded: start reruns it in full
        launch(0, 1'b1, 1'b1);
        wait_idle("rerun");
        check("rerun_inj_done", injections_done, 16'd2);

        // Reset during GAP
        load_cfg(1'b0, 32'd0, 32'd7, 16'd5, 16'd0, 16'd1, 16'd4, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd0); plan.push_back(32'd7); plan.push_back(32'd14);
        plan.push_back(32'd21); plan.push_back(32'd28);
        launch(0, 1'b1, 1'b1);
        wait_inject_active(1'b1);
        wait_inject_active(1'b0);
        check("pre_reset_in_gap_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        inj_q.delete();
        done_q.delete();
        abort_q.delete();
        check_reset_values();
        reset = 1'b0;
        // Config-loaded flag was cleared: start alone does nothing
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("post_reset_start_ignored", busy, 1'b0);
        load_cfg(1'b0, 32'd2, 32'd30, 16'd3, 16'd2, 16'd3, 16'd0, 1'b0, 1'b0);
        plan.delete();
        plan.push_back(32'd2); plan.push_back(32'd32); plan.push_back(32'd62);
        launch(0, 1'b1, 1'b1);
        wait_idle("post_reset_sweep");
        check("post_reset_inj_done", injections_done, 16'd3);

        // Random mode on the TOTAL_BITS=40 instance; stride is not checked
        load_cfg(1'b1, 32'd3, 32'd100, 16'd200, 16'd0, 16'd1, 16'd0, 1'b0, 1'b1);
        @(negedge clock);
        r_start = 1'b1;
        @(negedge clock);
        r_start = 1'b0;
        check("rand_busy_after_start", r_busy, 1'b1);
        guard = 0;
        while (r_busy && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        if (r_busy) fail_event("timeout_random", cyc);
        repeat (2) @(negedge clock);
        distinct = 0;
        for (int i = 0; i < 64; i++) if (seen[i]) distinct++;
        check("rand_injection_count", r_runs, 200);
        check("rand_distinct_ge_30", distinct >= 30, 1'b1);
        check("rand_done_once", r_done_seen, 1);
        check("rand_inj_done", r_injections_done, 16'd200);
        check("rand_idle_state", r_inj_state, EXP_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/verinject_injection_scheduler.md
# verinject_injection_scheduler

Campaign controller that drives the shared `verinject__injector_state` bus fed to every `verinject_*_injector` in a design. It steps through a configured set of flattened fault-bit indices, presenting each one for a programmable number of cycles with idle gaps between them. It sits at the top of the instrumented design, between the testbench or host configuration interface and the injector tree. In sweep mode it sequences targets deterministically; in random mode it picks in-range targets from an LFSR.

## Interface
- `TOTAL_BITS`, default 1024: size of the flattened injectable bit space. Must be ≤ 32'hFFFF_FFFE.
- `LFSR_SEED`, default 32'hACE1_2468: reset seed for random mode. Must be nonzero.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: high in IDLE only.
- `cfg_mode` in 1: 0 = sweep, 1 = random.
- `cfg_first` in 32: first target bit index (sweep mode).
- `cfg_stride` in 32: target increment (sweep mode).
- `cfg_count` in 16: number of injections in the campaign.
- `cfg_delay` in 16: cycles from start to the first injection.
- `cfg_hold` in 16: cycles each target is held. 0 is treated as 1.
- `cfg_gap` in 16: idle cycles between injections.
- `cfg_error` out 1: sticky error flag; cleared by the next accepted config.
- `start` in 1: begin campaign. Honoured only in IDLE with a valid config loaded.
- `abort` in 1: terminate the campaign immediately.
- `verinject__injector_state` out 32: registered. Carries the target during INJECT and IDLE_STATE otherwise.
- `inject_active` out 1: high during INJECT.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.
- `injections_done` out 16: number of completed injections in the current campaign.

## Operation
- Reset values: `verinject__injector_state` = IDLE_STATE (32'hFFFF_FFFF). All flags are 0, `injections_done` = 0, the config-loaded flag is cleared, and the LFSR is loaded with LFSR_SEED.
- FSM states: IDLE, DELAY, PICK, INJECT, GAP.
  - IDLE→DELAY on `start` when the config is loaded and valid.
  - DELAY→PICK when the delay counter expires.
  - PICK→INJECT once a target is chosen.
  - INJECT→GAP after `hold` cycles; if this was the last injection, INJECT→IDLE and `done` pulses.
  - GAP→PICK after `gap` cycles.
- Sweep mode: the first target is `cfg_first`; each subsequent target is `(prev + stride) mod TOTAL_BITS`.
  - Compute the sum in 33 bits and subtract TOTAL_BITS once if the sum is ≥ TOTAL_BITS.
  - PICK takes exactly 1 cycle.
- Random mode: PICK advances the LFSR once per cycle and masks the value to `2^ceil(log2(TOTAL_BITS)) - 1`.
  - Values ≥ TOTAL_BITS are rejected and PICK retries.
  - A value is accepted on the cycle it is in range.
- Config check on acceptance:
  - `cfg_error` is set and the config is not loaded if `cfg_first` ≥ TOTAL_BITS, or if `cfg_stride` ≥ TOTAL_BITS in sweep mode.
  - `cfg_stride` = 0 is legal and repeats the same target.
- `cfg_count` = 0: `start` gives `done` on the next cycle with no injection.
- `abort` has priority over every other event. Any state goes to IDLE next cycle, the output returns to IDLE_STATE, and `aborted` pulses (only if `busy` was high). `done` does not pulse.
- `start` while busy is ignored. `cfg_valid` while busy is not accepted.
- `injections_done` increments at each INJECT exit and is cleared on `start`.
- The config stays loaded after a campaign, so a new `start` reruns it. The LFSR is not reseeded between campaigns.

## Timing
- `start` sampled at edge t: `busy` is high from t+1.
- Sweep mode: the first INJECT cycle (output = target) is t+2+delay, counting the DELAY state plus the 1-cycle PICK.
- INJECT holds the output for exactly max(hold,1) cycles. GAP lasts exactly `gap` cycles; gap = 0 means PICK follows INJECT directly. Consecutive sweep targets are therefore separated by gap+1 idle cycles.
- `done` is asserted on the first cycle back in IDLE, concurrent with the output returning to IDLE_STATE.
- Reset mid-INJECT: the output is IDLE_STATE after the reset edge. No `done` or `aborted` pulse.

## Structure
- Package `verinject_pkg`:
  - IDLE_STATE constant
  - FSM state enum
  - LFSR polynomial (Galois, taps 32,22,2,1 = 32'h8020_0003)
  - counter width constants
- Sub-module `verinject_lfsr32`: enable, load, seed, 32-bit state output. Its state is never zero.

## Test plan
- Sweep with TOTAL_BITS=64, first=5, stride=20, count=4, hold=2, gap=1, delay=0 → targets 5, 25, 45, 1; each held 2 cycles with 2 idle cycles between; `done` at the end; `injections_done`=4.
- count=0, then `start` → `done` on the next cycle; output stays 32'hFFFF_FFFF throughout.
- Config with first=64 when TOTAL_BITS=64 → `cfg_error`=1; a following `start` is ignored and `busy` stays 0.
- `abort` on the second INJECT cycle of hold=5 → next cycle IDLE, output 32'hFFFF_FFFF, `aborted`=1, `done`=0.
- Random mode, TOTAL_BITS=40, count=200 → every presented target < 40, with at least 30 distinct values.
- `reset` asserted during GAP → all outputs at reset values; a new config plus `start` runs normally.
